// File: rtl/time_counter_bcd_pkg.sv
// Shared types, BCD limits and digit-arithmetic helpers for the BCD time counter.
package time_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PAIR_W  = 8;
   localparam int unsigned TOTAL_W = 32;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;
   typedef logic [PAIR_W-1:0]  bcd_pair_t;

   typedef struct packed {
      bcd_pair_t hh;
      bcd_pair_t mm;
      bcd_pair_t ss;
   } bcd_time_t;

   localparam bcd_pair_t BCD_59 = 8'h59;
   localparam bcd_pair_t BCD_23 = 8'h23;
   localparam bcd_pair_t BCD_99 = 8'h99;

   localparam bcd_digit_t DIGIT_9 = 4'd9;

   function automatic logic bcd_pair_valid(input bcd_pair_t pair, input bcd_pair_t max);
      return (pair[7:4] <= DIGIT_9) && (pair[3:0] <= DIGIT_9) && (pair <= max);
   endfunction

   // Up-step of a BCD pair, wrapping max -> 00.
   function automatic bcd_pair_t bcd_inc(input bcd_pair_t pair, input bcd_pair_t max);
      bcd_digit_t hi;
      bcd_digit_t lo;
      hi = pair[7:4];
      lo = pair[3:0];
      if (pair == max)       return '0;
      else if (lo == DIGIT_9) return {bcd_digit_t'(hi + 4'd1), 4'd0};
      else                   return {hi, bcd_digit_t'(lo + 4'd1)};
   endfunction

   // Down-step of a BCD pair, wrapping 00 -> max.
   function automatic bcd_pair_t bcd_dec(input bcd_pair_t pair, input bcd_pair_t max);
      bcd_digit_t hi;
      bcd_digit_t lo;
      hi = pair[7:4];
      lo = pair[3:0];
      if (pair == '0)      return max;
      else if (lo == 4'd0) return {bcd_digit_t'(hi - 4'd1), DIGIT_9};
      else                 return {hi, bcd_digit_t'(lo - 4'd1)};
   endfunction

endpackage

// File: rtl/time_counter_bcd_if.sv
// Control and status bundle of the BCD time counter.
interface time_counter_bcd_if
   import time_counter_pkg::*;
   ;
   logic                 run;
   logic                 dir_down;
   logic                 clear;
   logic                 load;
   bcd_time_t            load_time;
   bcd_time_t            bcd_time;
   logic [TOTAL_W-1:0]   sec_total;
   logic                 tick;
   logic                 load_err;

   modport master (
      output run, dir_down, clear, load, load_time,
      input  bcd_time, sec_total, tick, load_err
   );

   modport slave (
      input  run, dir_down, clear, load, load_time,
      output bcd_time, sec_total, tick, load_err
   );
endinterface

// File: rtl/time_counter_bcd_pair.sv
// One BCD digit pair (SS, MM or HH) with up/down step, load and clear.
module bcd_pair_counter
   import time_counter_pkg::*;
#(
   parameter bcd_pair_t MAX_BCD = BCD_59
) (
   input  logic      clock,
   input  logic      reset_n,
   input  logic      step,
   input  logic      down,
   input  logic      load,
   input  logic      clr,
   input  bcd_pair_t load_val,
   output bcd_pair_t value,
   output logic      carry
);

   // Wrap indication feeds the next pair's step in the same cycle.
   assign carry = step && (down ? (value == '0) : (value == MAX_BCD));

   always_ff @(posedge clock) begin
      if (!reset_n)  value <= '0;
      else if (clr)  value <= '0;
      else if (load) value <= load_val;
      else if (step) value <= down ? bcd_dec(value, MAX_BCD) : bcd_inc(value, MAX_BCD);
   end

endmodule

// File: rtl/time_counter_bcd.sv
// HH:MM:SS BCD time counter with prescaled tick, run/pause, up/down, clear and preset.
module time_counter_bcd
   import time_counter_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 25_000_000,
   parameter int unsigned TICK_HZ  = 1,
   parameter bit          MODE_24H = 1'b1
) (
   input logic               clock,
   input logic               reset_n,
   time_counter_bcd_if.slave bus
);

   localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam bcd_pair_t   HH_MAX = MODE_24H ? BCD_23 : BCD_99;

   if (((CLK_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_param_check
      $error("time_counter_bcd: CLK_HZ must be a multiple of TICK_HZ with DIV >= 2");
   end

   logic [PRE_W-1:0] presc;
   logic             terminal_c;
   logic             load_ok_c;
   logic             tick_en_c;
   bcd_pair_t        ss_val, mm_val, hh_val;
   logic             ss_carry, mm_carry, hh_carry;

   assign terminal_c = (presc == PRE_W'(DIV - 1));
   assign load_ok_c  = bus.load
                       && bcd_pair_valid(bus.load_time.ss, BCD_59)
                       && bcd_pair_valid(bus.load_time.mm, BCD_59)
                       && bcd_pair_valid(bus.load_time.hh, HH_MAX);
   // Any load request, valid or not, suppresses counting that cycle.
   assign tick_en_c  = bus.run && terminal_c && !bus.clear && !bus.load;

   always_ff @(posedge clock) begin
      if (!reset_n)       presc <= '0;
      else if (bus.clear) presc <= '0;
      else if (bus.load) begin
         if (load_ok_c)   presc <= '0;
      end
      else if (bus.run)   presc <= terminal_c ? '0 : presc + PRE_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset_n || bus.clear) begin
         bus.sec_total <= '0;
         bus.tick      <= 1'b0;
         bus.load_err  <= 1'b0;
      end else begin
         bus.tick <= tick_en_c;
         if (tick_en_c) bus.sec_total <= bus.sec_total + TOTAL_W'(1);
         if (bus.load)  bus.load_err  <= !load_ok_c;
      end
   end

   bcd_pair_counter #(.MAX_BCD(BCD_59)) u_ss (
      .clock    (clock),
      .reset_n  (reset_n),
      .step     (tick_en_c),
      .down     (bus.dir_down),
      .load     (load_ok_c),
      .clr      (bus.clear),
      .load_val (bus.load_time.ss),
      .value    (ss_val),
      .carry    (ss_carry)
   );

   bcd_pair_counter #(.MAX_BCD(BCD_59)) u_mm (
      .clock    (clock),
      .reset_n  (reset_n),
      .step     (ss_carry),
      .down     (bus.dir_down),
      .load     (load_ok_c),
      .clr      (bus.clear),
      .load_val (bus.load_time.mm),
      .value    (mm_val),
      .carry    (mm_carry)
   );

   bcd_pair_counter #(.MAX_BCD(HH_MAX)) u_hh (
      .clock    (clock),
      .reset_n  (reset_n),
      .step     (mm_carry),
      .down     (bus.dir_down),
      .load     (load_ok_c),
      .clr      (bus.clear),
      .load_val (bus.load_time.hh),
      .value    (hh_val),
      .carry    (hh_carry)
   );

   assign bus.bcd_time = {hh_val, mm_val, ss_val};

   // Hours can only wrap while minutes are carrying into them.
   always_ff @(posedge clock) begin
      if (reset_n) assert (!hh_carry || mm_carry);
   end

endmodule

// File: tb/tb_time_counter_bcd.sv
// Directed bench for time_counter_bcd: table of vectors plus hand-written corner sequences.
module tb_time_counter_bcd;
   import time_counter_pkg::*;

   logic        clock;
   logic        reset_n;
   logic        run, dir_down, clear, load;
   logic [23:0] load_time;

   int n_chk;
   int n_fail;

   time_counter_bcd_if ifa ();
   time_counter_bcd_if ifb ();

   assign ifa.run       = run;
   assign ifa.dir_down  = dir_down;
   assign ifa.clear     = clear;
   assign ifa.load      = load;
   assign ifa.load_time = load_time;
   assign ifb.run       = run;
   assign ifb.dir_down  = dir_down;
   assign ifb.clear     = clear;
   assign ifb.load      = load;
   assign ifb.load_time = load_time;

   time_counter_bcd #(.CLK_HZ(10), .TICK_HZ(1), .MODE_24H(1'b1)) dut_24 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifa.slave)
   );

   time_counter_bcd #(.CLK_HZ(10), .TICK_HZ(1), .MODE_24H(1'b0)) dut_99 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifb.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      int          ncyc;
      logic        run;
      logic        dir_down;
      logic        clear;
      logic        load;
      logic [23:0] load_time;
      logic [23:0] exp_time;
      logic [31:0] exp_total;
      logic        exp_tick;
      logic        exp_err;
   } vec_t;

   vec_t vecs[17];

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [23:0] t, input logic [31:0] tot,
                        input logic tk, input logic err);
      chk({nm, ".time"},  32'(ifa.bcd_time), 32'(t));
      chk({nm, ".total"}, ifa.sec_total,     tot);
      chk({nm, ".tick"},  32'(ifa.tick),     32'(tk));
      chk({nm, ".err"},   32'(ifa.load_err), 32'(err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset_n = 1'b0; run = 1'b1; dir_down = 1'b0; clear = 1'b0; load = 1'b0;
      load_time = 24'h0;

      //          name       ncyc run dn clr ld  load_time  exp_time   total tick err
      vecs[0]  = '{"up1",     10, 1, 0, 0, 0, 24'h000000, 24'h000001, 1, 1, 0};
      vecs[1]  = '{"up2",     10, 1, 0, 0, 0, 24'h000000, 24'h000002, 2, 1, 0};
      vecs[2]  = '{"up3",     10, 1, 0, 0, 0, 24'h000000, 24'h000003, 3, 1, 0};
      vecs[3]  = '{"pre9",     9, 1, 0, 0, 0, 24'h000000, 24'h000003, 3, 0, 0};
      vecs[4]  = '{"up4",      1, 1, 0, 0, 0, 24'h000000, 24'h000004, 4, 1, 0};
      vecs[5]  = '{"ld2359",   1, 1, 0, 0, 1, 24'h235959, 24'h235959, 4, 0, 0};
      vecs[6]  = '{"wrapup",  10, 1, 0, 0, 0, 24'h000000, 24'h000000, 5, 1, 0};
      vecs[7]  = '{"ld0000",   1, 1, 1, 0, 1, 24'h000000, 24'h000000, 5, 0, 0};
      vecs[8]  = '{"wrapdn",  10, 1, 1, 0, 0, 24'h000000, 24'h235959, 6, 1, 0};
      vecs[9]  = '{"dn2",     10, 1, 1, 0, 0, 24'h000000, 24'h235958, 7, 1, 0};
      vecs[10] = '{"badmm",    1, 1, 0, 0, 1, 24'h006000, 24'h235958, 7, 0, 1};
      vecs[11] = '{"badhex",   1, 1, 0, 0, 1, 24'h0A0000, 24'h235958, 7, 0, 1};
      vecs[12] = '{"ld1200",   1, 1, 0, 0, 1, 24'h120000, 24'h120000, 7, 0, 0};
      vecs[13] = '{"up1200",  10, 1, 0, 0, 0, 24'h000000, 24'h120001, 8, 1, 0};
      vecs[14] = '{"clear",    1, 1, 0, 1, 0, 24'h000000, 24'h000000, 0, 0, 0};
      vecs[15] = '{"clr9",     9, 1, 0, 0, 0, 24'h000000, 24'h000000, 0, 0, 0};
      vecs[16] = '{"clr10",    1, 1, 0, 0, 0, 24'h000000, 24'h000001, 1, 1, 0};

      repeat (3) cyc();
      chk_a("reset", 24'h000000, 0, 1'b0, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         run = vecs[i].run; dir_down = vecs[i].dir_down;
         clear = vecs[i].clear; load = vecs[i].load; load_time = vecs[i].load_time;
         cyc();
         clear = 1'b0; load = 1'b0;
         repeat (vecs[i].ncyc - 1) cyc();
         chk_a(vecs[i].name, vecs[i].exp_time, vecs[i].exp_total, vecs[i].exp_tick, vecs[i].exp_err);
      end
      chk("tbl.time99", 32'(ifb.bcd_time), 32'h000001);

      // Pause at prescaler 5 for 20 cycles, then exactly 5 more cycles to the tick.
      repeat (5) cyc();
      run = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("pause.tick", 32'(ifa.tick), 0);
      end
      chk_a("paused", 24'h000001, 1, 1'b0, 1'b0);
      run = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("resume.tick", 32'(ifa.tick), 32'(i == 5));
      end
      chk_a("resumed", 24'h000002, 2, 1'b1, 1'b0);

      // Load lands on the terminal-count cycle: load wins, no tick.
      repeat (9) cyc();
      chk("tc.pre", 32'(ifa.tick), 0);
      load = 1'b1; load_time = 24'h101010;
      cyc();
      load = 1'b0;
      chk_a("tc.load", 24'h101010, 2, 1'b0, 1'b0);
      repeat (9) cyc();
      chk("tc.after9", 32'(ifa.tick), 0);
      cyc();
      chk_a("tc.after10", 24'h101011, 3, 1'b1, 1'b0);

      // Reset overrides simultaneous load and clear mid-count.
      load = 1'b1; load_time = 24'h000060;
      cyc();
      load = 1'b0;
      chk_a("badss", 24'h101011, 3, 1'b0, 1'b1);
      repeat (4) cyc();
      reset_n = 1'b0; load = 1'b1; clear = 1'b1; load_time = 24'h123456;
      cyc();
      chk_a("rst.mid", 24'h000000, 0, 1'b0, 1'b0);
      chk("rst.time99", 32'(ifb.bcd_time), 0);
      reset_n = 1'b1; load = 1'b0; clear = 1'b0;

      // Clear at sec_total=7 restarts the full prescaler period.
      repeat (70) cyc();
      chk_a("cnt7", 24'h000007, 7, 1'b1, 1'b0);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk_a("clr7", 24'h000000, 0, 1'b0, 1'b0);
      repeat (9) cyc();
      chk("clr7.9", 32'(ifa.tick), 0);
      cyc();
      chk_a("clr7.10", 24'h000001, 1, 1'b1, 1'b0);

      // 24h vs 99h hour range.
      load = 1'b1; load_time = 24'h995959;
      cyc();
      load = 1'b0;
      chk("m99.err24", 32'(ifa.load_err), 1);
      chk("m99.time24", 32'(ifa.bcd_time), 32'h000001);
      chk("m99.err99", 32'(ifb.load_err), 0);
      chk("m99.time99", 32'(ifb.bcd_time), 32'h995959);
      repeat (10) cyc();
      chk("m99.up24", 32'(ifa.bcd_time), 32'h000002);
      chk("m99.up99", 32'(ifb.bcd_time), 32'h000000);
      chk("m99.tick99", 32'(ifb.tick), 1);

      load = 1'b1; load_time = 24'h000000; dir_down = 1'b1;
      cyc();
      load = 1'b0;
      repeat (10) cyc();
      chk("dn.time24", 32'(ifa.bcd_time), 32'h235959);
      chk("dn.time99", 32'(ifb.bcd_time), 32'h995959);
      chk("dn.err24", 32'(ifa.load_err), 0);
      repeat (10) cyc();
      chk("dn2.time24", 32'(ifa.bcd_time), 32'h235958);
      chk("dn2.time99", 32'(ifb.bcd_time), 32'h995958);

      load = 1'b1; load_time = 24'h235959; dir_down = 1'b0;
      cyc();
      load = 1'b0;
      repeat (10) cyc();
      chk("up23.time24", 32'(ifa.bcd_time), 32'h000000);
      chk("up23.time99", 32'(ifb.bcd_time), 32'h240000);
      chk("up23.total", ifa.sec_total, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
